fpu_issuer: RTL and testbench

//  Initiator side of the fpu operand/result handshake. Accepts one tagged request (op, a, b) from the core via valid/ready.

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fpu_watchdog.sv | 43 ++++
 rtl/fpu_issuer.sv | 199 +++++++++++++++++++
 tb/tb_fpu_issuer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu issuer and its watchdog.
package fpu_pkg;

  localparam int FPU_DATA_WIDTH = 32;
  localparam int FPU_OP_WIDTH   = 4;
  localparam int FPU_TAG_WIDTH  = 4;

  // Result returned to the core when the fpu never answers.
  localparam logic [FPU_DATA_WIDTH-1:0] FPU_NAN_RESULT = 32'hFFFF_FFFF;

  typedef logic [FPU_OP_WIDTH-1:0] fpu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    ACK,
    RESP
  } issuer_state_t;

  typedef struct packed {
    fpu_op_t                  op;
    logic [FPU_DATA_WIDTH-1:0] a;
    logic [FPU_DATA_WIDTH-1:0] b;
    logic [FPU_TAG_WIDTH-1:0]  tag;
  } fpu_req_t;

  typedef struct packed {
    logic [FPU_DATA_WIDTH-1:0] result;
    logic [FPU_TAG_WIDTH-1:0]  tag;
    logic                      err;
  } fpu_rsp_t;

endpackage

// File: rtl/fpu_watchdog.sv
// Cycle counter that flags a hung fpu transaction. The count clears on
// clear_i, advances while enable_i is high and saturates at TIMEOUT.
// expired_o fires on the cycle whose closing edge would bring the count to
// TIMEOUT, so the owner leaves exactly TIMEOUT cycles after the clear.
// TIMEOUT = 0 disables the watchdog.
module fpu_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear has priority, then saturating increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != MAX_CNT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (TIMEOUT > 0) && enable_i && (count_q == LAST_CNT);

endmodule

// File: rtl/fpu_issuer.sv
// Initiator side of the fpu operand/result four-phase handshakes. Takes one
// tagged request from the core, feeds the fpu, captures its result and hands
// back a tagged response. A watchdog turns a hung fpu into an error response.
module fpu_issuer
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = FPU_DATA_WIDTH,
  parameter int OP_WIDTH   = FPU_OP_WIDTH,
  parameter int TAG_WIDTH  = FPU_TAG_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_WIDTH-1:0]   req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  input_rdy,
  input  logic                  input_ack,
  output logic [OP_WIDTH-1:0]   operation,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  input  logic                  output_rdy,
  output logic                  output_ack,
  input  logic [DATA_WIDTH-1:0] result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_err,
  output logic                  busy
);

  issuer_state_t         state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  input_rdy_q, input_rdy_d;
  logic                  output_ack_q, output_ack_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic accept;
  logic wd_enable;
  logic wd_expired;

  assign accept    = (state_q == IDLE) && req_valid && req_ready_q;
  assign wd_enable = (state_q == ISSUE) || (state_q == WAIT_RES);

  fpu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (accept),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  // Next-state and registered-output logic of the handshake FSM.
  always_comb begin
    // NOTE: every _d starts from its _q, so a path that assigns nothing
    // holds the register instead of inferring a latch.
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    input_rdy_d  = input_rdy_q;
    output_ack_d = output_ack_q;
    rsp_valid_d  = rsp_valid_q;
    err_d        = err_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    tag_d        = tag_q;
    result_d     = result_q;

    case (state_q)
      IDLE: begin
        // A late fpu result after a timeout is acked and dropped here.
        output_ack_d = output_rdy;
        req_ready_d  = !output_rdy;
        if (accept) begin
          op_d        = req_op;
          a_d         = req_a;
          b_d         = req_b;
          tag_d       = req_tag;
          err_d       = 1'b0;
          input_rdy_d = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (input_ack && output_rdy) begin
          // Capture beats a coincident watchdog expiry.
          result_d     = result;
          input_rdy_d  = 1'b0;
          output_ack_d = 1'b1;
          state_d      = ACK;
        end else if (wd_expired) begin
          input_rdy_d  = 1'b0;
          output_ack_d = 1'b0;
          result_d     = DATA_WIDTH'(FPU_NAN_RESULT);
          err_d        = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else if (input_ack) begin
          input_rdy_d = 1'b0;
          state_d     = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (output_rdy) begin
          result_d     = result;
          output_ack_d = 1'b1;
          state_d      = ACK;
        end else if (wd_expired) begin
          output_ack_d = 1'b0;
          result_d     = DATA_WIDTH'(FPU_NAN_RESULT);
          err_d        = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      ACK: begin
        if (!output_rdy) begin
          output_ack_d = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = !output_rdy;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      input_rdy_q  <= 1'b0;
      output_ack_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      // NOTE: the operand/tag/result registers are reset too, because they
      // drive outputs directly and those must read 0 while reset is held.
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      tag_q        <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      input_rdy_q  <= input_rdy_d;
      output_ack_q <= output_ack_d;
      rsp_valid_q  <= rsp_valid_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tag_q        <= tag_d;
      result_q     <= result_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign input_rdy  = input_rdy_q;
  assign output_ack = output_ack_q;
  assign operation  = op_q;
  assign data_a     = a_q;
  assign data_b     = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_tag    = tag_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fpu_issuer.sv
// Bench for fpu_issuer: a behavioural fpu (truncating single-precision
// add/sub, random latency), a manually driven fpu stub for corner cases, and
// a second instance with a short watchdog for timeout behaviour.
module tb_fpu_issuer;
  import fpu_pkg::*;

  localparam int WD_TIMEOUT = 8;
  localparam int N_RAND     = 24;

  logic        clock = 1'b0;
  logic        reset;

  // Main instance.
  logic        req_valid, req_ready;
  logic [3:0]  req_op, req_tag;
  logic [31:0] req_a, req_b;
  logic        input_rdy, input_ack;
  logic [3:0]  operation;
  logic [31:0] data_a, data_b;
  logic        output_rdy, output_ack;
  logic [31:0] result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err, busy;

  // fpu side: either the automatic model or the manual stub.
  logic        auto_fpu;
  logic        f_ack, f_rdy, m_ack, m_rdy;
  logic [31:0] f_res, m_res;
  assign input_ack  = auto_fpu ? f_ack : m_ack;
  assign output_rdy = auto_fpu ? f_rdy : m_rdy;
  assign result     = auto_fpu ? f_res : m_res;

  // Watchdog instance (stub fpu never answers unless driven).
  logic        w_req_valid, w_req_ready;
  logic [3:0]  w_req_op, w_req_tag;
  logic [31:0] w_req_a, w_req_b;
  logic        w_input_rdy, w_input_ack;
  logic [3:0]  w_operation;
  logic [31:0] w_data_a, w_data_b;
  logic        w_output_rdy, w_output_ack;
  logic [31:0] w_result;
  logic        w_rsp_valid, w_rsp_ready;
  logic [31:0] w_rsp_result;
  logic [3:0]  w_rsp_tag;
  logic        w_rsp_err, w_busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fpu_issuer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .input_rdy(input_rdy), .input_ack(input_ack), .operation(operation),
    .data_a(data_a), .data_b(data_b),
    .output_rdy(output_rdy), .output_ack(output_ack), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  fpu_issuer #(.TIMEOUT(WD_TIMEOUT)) dut_wd (
    .clock(clock), .reset(reset),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_op(w_req_op),
    .req_a(w_req_a), .req_b(w_req_b), .req_tag(w_req_tag),
    .input_rdy(w_input_rdy), .input_ack(w_input_ack), .operation(w_operation),
    .data_a(w_data_a), .data_b(w_data_b),
    .output_rdy(w_output_rdy), .output_ack(w_output_ack), .result(w_result),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_result(w_rsp_result),
    .rsp_tag(w_rsp_tag), .rsp_err(w_rsp_err), .busy(w_busy)
  );

  // ---------------- reference fpu arithmetic ----------------
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) return 0.0;
    d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Round toward zero, matching the fpu used by the core.
  function automatic logic [31:0] r2s_trunc(input real x);
    logic [63:0] d;
    logic [10:0] e;
    if (x == 0.0) return 32'd0;
    d = $realtobits(x);
    e = d[62:52];
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  // op 1 = subtract, anything else = add.
  function automatic logic [31:0] fp_exec(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    real ra, rb;
    ra = s2r(a);
    rb = s2r(b);
    if (op == 4'd1) rb = -rb;
    return r2s_trunc(ra + rb);
  endfunction

  // Normal operands with close exponents keep the double sum exact.
  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    return {r[31], 8'(120 + $urandom_range(0, 14)), r[22:0]};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return rsp_valid;
      1:       return input_rdy;
      2:       return output_ack;
      default: return w_rsp_valid;
    endcase
  endfunction

  task automatic wait_high(input int which, input int budget, input string tag, output int n);
    n = 0;
    while (sel(which) !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_seen"}, 64'(sel(which)), 64'd1);
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
  endtask

  // ---------------- automatic fpu with random latency ----------------
  initial begin
    int lat;
    logic [31:0] r;
    f_ack = 1'b0;
    f_rdy = 1'b0;
    f_res = '0;
    forever begin
      @(negedge clock);
      if (auto_fpu && input_rdy && !f_ack) begin
        r     = fp_exec(operation, data_a, data_b);
        f_ack = 1'b1;
        do @(negedge clock); while (input_rdy);
        f_ack = 1'b0;
        lat   = $urandom_range(1, 20);
        repeat (lat - 1) @(negedge clock);
        f_res = r;
        f_rdy = 1'b1;
        do @(negedge clock); while (!output_ack);
        f_rdy = 1'b0;
        do @(negedge clock); while (output_ack);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    int n;
    logic saw;
    fpu_req_t reqs[N_RAND];
    fpu_rsp_t exp_q[$];
    fpu_rsp_t e;
    logic [3:0] got_tags[$];
    int sent, cyc;
    logic acc_pending;

    reset = 1'b0;
    auto_fpu = 1'b0;
    req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_tag = 0;
    rsp_ready = 0;
    m_ack = 0; m_rdy = 0; m_res = 0;
    w_req_valid = 0; w_req_op = 0; w_req_a = 0; w_req_b = 0; w_req_tag = 0;
    w_input_ack = 0; w_output_rdy = 0; w_result = 0; w_rsp_ready = 0;
    repeat (3) step();

    // Reset state.
    check("rst_req_ready", 64'(req_ready), 1);
    check("rst_input_rdy", 64'(input_rdy), 0);
    check("rst_output_ack", 64'(output_ack), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_rsp_result", 64'(rsp_result), 0);
    check("rst_rsp_tag", 64'(rsp_tag), 0);
    check("rst_rsp_err", 64'(rsp_err), 0);
    check("rst_data_a", 64'(data_a), 0);
    check("rst_w_req_ready", 64'(w_req_ready), 1);
    reset = 1'b1;
    step();

    // 1: simple add, one-cycle issue latency.
    auto_fpu  = 1'b1;
    rsp_ready = 1'b1;
    drive_req(4'd0, 32'h3F80_0000, 32'h3C23_D70A, 4'd3);
    check("t1_ready_at_accept", 64'(req_ready), 1);
    check("t1_inrdy_before", 64'(input_rdy), 0);
    step();
    req_valid = 1'b0;
    check("t1_inrdy_next", 64'(input_rdy), 1);
    check("t1_req_ready_low", 64'(req_ready), 0);
    check("t1_busy", 64'(busy), 1);
    check("t1_operation", 64'(operation), 0);
    check("t1_data_a", 64'(data_a), 64'h3F80_0000);
    check("t1_data_b", 64'(data_b), 64'h3C23_D70A);
    wait_high(0, 100, "t1_rsp", n);
    check("t1_result", 64'(rsp_result), 64'h3F81_47AE);
    check("t1_tag", 64'(rsp_tag), 3);
    check("t1_err", 64'(rsp_err), 0);
    step();
    check("t1_rsp_done", 64'(rsp_valid), 0);
    check("t1_req_ready_back", 64'(req_ready), 1);

    // 2: response back-pressure for five cycles.
    rsp_ready = 1'b0;
    drive_req(4'd0, 32'h41A8_0000, 32'h3E94_7AE1, 4'd9);
    step();
    req_valid = 1'b0;
    wait_high(0, 100, "t2_rsp", n);
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_valid", 64'(rsp_valid), 1);
      check("t2_hold_result", 64'(rsp_result), 64'h41AA_51EB);
      check("t2_hold_tag", 64'(rsp_tag), 9);
      check("t2_req_ready_low", 64'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    check("t2_req_ready_at_rsp_ready", 64'(req_ready), 0);
    step();
    check("t2_rsp_done", 64'(rsp_valid), 0);
    check("t2_req_ready_after", 64'(req_ready), 1);

    // 4: input_ack and output_rdy together skip WAIT_RES.
    auto_fpu = 1'b0;
    drive_req(4'd1, 32'h4049_0FDB, 32'h3F80_0000, 4'd6);
    step();
    req_valid = 1'b0;
    check("t4_inrdy", 64'(input_rdy), 1);
    m_ack = 1'b1;
    m_rdy = 1'b1;
    m_res = 32'h4016_CBE4;
    step();
    check("t4_inrdy_drop", 64'(input_rdy), 0);
    check("t4_oack_direct", 64'(output_ack), 1);
    check("t4_capture", 64'(rsp_result), 64'h4016_CBE4);
    m_ack = 1'b0;
    m_res = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      check("t4_oack_hold", 64'(output_ack), 1);
      check("t4_no_rsp_yet", 64'(rsp_valid), 0);
      step();
    end
    m_rdy = 1'b0;
    step();
    check("t4_oack_release", 64'(output_ack), 0);
    check("t4_rsp_valid", 64'(rsp_valid), 1);
    check("t4_result_kept", 64'(rsp_result), 64'h4016_CBE4);
    check("t4_tag", 64'(rsp_tag), 6);
    check("t4_err", 64'(rsp_err), 0);
    step();
    check("t4_rsp_done", 64'(rsp_valid), 0);

    // 5: reset while in ACK.
    drive_req(4'd0, 32'h1234_5678, 32'h0BAD_F00D, 4'd7);
    step();
    req_valid = 1'b0;
    check("t5_inrdy", 64'(input_rdy), 1);
    m_ack = 1'b1;
    step();
    check("t5_wait_res", 64'(input_rdy), 0);
    m_ack = 1'b0;
    m_rdy = 1'b1;
    m_res = 32'h4000_0000;
    step();
    check("t5_in_ack_state", 64'(output_ack), 1);
    #2 reset = 1'b0;
    #1;
    check("t5_async_req_ready", 64'(req_ready), 1);
    check("t5_async_output_ack", 64'(output_ack), 0);
    check("t5_async_input_rdy", 64'(input_rdy), 0);
    check("t5_async_rsp_valid", 64'(rsp_valid), 0);
    check("t5_async_busy", 64'(busy), 0);
    check("t5_async_result", 64'(rsp_result), 0);
    check("t5_async_tag", 64'(rsp_tag), 0);
    check("t5_async_data_a", 64'(data_a), 0);
    m_rdy = 1'b0;
    step();
    reset = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      step();
      if (rsp_valid) saw = 1'b1;
    end
    check("t5_no_rsp_pulse", 64'(saw), 0);
    check("t5_req_ready_after", 64'(req_ready), 1);

    // 3: watchdog expiry on the TIMEOUT=8 instance.
    w_req_valid = 1'b1;
    w_req_tag   = 4'd5;
    w_req_a     = 32'h3F80_0000;
    step();
    w_req_valid = 1'b0;
    check("t3_inrdy", 64'(w_input_rdy), 1);
    wait_high(3, 50, "t3_rsp", n);
    check("t3_latency", 64'(n), 64'(WD_TIMEOUT));
    check("t3_err", 64'(w_rsp_err), 1);
    check("t3_nan", 64'(w_rsp_result), 64'(FPU_NAN_RESULT));
    check("t3_inrdy_low", 64'(w_input_rdy), 0);
    check("t3_oack_low", 64'(w_output_ack), 0);
    check("t3_tag", 64'(w_rsp_tag), 5);
    w_rsp_ready = 1'b1;
    step();
    check("t3_rsp_done", 64'(w_rsp_valid), 0);
    check("t3_req_ready_back", 64'(w_req_ready), 1);
    // Late fpu result in IDLE is acked and blocks new requests.
    w_output_rdy = 1'b1;
    step();
    check("t3_late_oack", 64'(w_output_ack), 1);
    check("t3_late_req_ready", 64'(w_req_ready), 0);
    check("t3_late_no_rsp", 64'(w_rsp_valid), 0);
    w_output_rdy = 1'b0;
    step();
    check("t3_late_oack_drop", 64'(w_output_ack), 0);
    check("t3_late_req_ready_back", 64'(w_req_ready), 1);
    // Next accept clears the error flag.
    w_req_valid = 1'b1;
    w_req_tag   = 4'hA;
    step();
    w_req_valid = 1'b0;
    check("t3_err_cleared", 64'(w_rsp_err), 0);
    check("t3_new_tag", 64'(w_rsp_tag), 64'hA);
    wait_high(3, 50, "t3b_rsp", n);
    check("t3b_latency", 64'(n), 64'(WD_TIMEOUT));
    step();

    // 6: back-to-back random requests against the fpu model.
    auto_fpu = 1'b1;
    for (int i = 0; i < N_RAND; i++) begin
      reqs[i].op  = (i < 2) ? 4'd0 : 4'($urandom_range(0, 1));
      reqs[i].a   = rand_fp();
      reqs[i].b   = rand_fp();
      reqs[i].tag = (i < 2) ? 4'(i + 1) : 4'($urandom_range(0, 15));
    end
    sent = 0;
    cyc = 0;
    acc_pending = 1'b0;
    drive_req(reqs[0].op, reqs[0].a, reqs[0].b, reqs[0].tag);
    while ((sent < N_RAND || exp_q.size() != 0) && cyc < 5000) begin
      if (acc_pending) begin
        sent++;
        acc_pending = 1'b0;
        if (sent < N_RAND) drive_req(reqs[sent].op, reqs[sent].a, reqs[sent].b, reqs[sent].tag);
        else req_valid = 1'b0;
      end
      if (req_valid && req_ready) begin
        acc_pending = 1'b1;
        e.result = fp_exec(req_op, req_a, req_b);
        e.tag    = req_tag;
        e.err    = 1'b0;
        exp_q.push_back(e);
      end
      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("t6_spurious_rsp", 64'(rsp_valid), 0);
        end else begin
          check("t6_result", 64'(rsp_result), 64'(exp_q[0].result));
          check("t6_tag", 64'(rsp_tag), 64'(exp_q[0].tag));
          check("t6_err", 64'(rsp_err), 64'(exp_q[0].err));
          if (rsp_ready) begin
            got_tags.push_back(rsp_tag);
            void'(exp_q.pop_front());
          end
        end
      end
      step();
      cyc++;
    end
    check("t6_all_sent", 64'(sent), 64'(N_RAND));
    check("t6_drained", 64'(exp_q.size()), 0);
    check("t6_rsp_count", 64'(got_tags.size()), 64'(N_RAND));
    if (got_tags.size() >= 2) begin
      check("t6_first_tag", 64'(got_tags[0]), 1);
      check("t6_second_tag", 64'(got_tags[1]), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
